acorn128_decryption: RTL and testbench
======================================

# acorn128_decryption

Bit-serial ACORN-128 decryption engine, the receive-side counterpart of the encryption stage. It takes the 293-bit state left by associated-data processing and a 128-bit ciphertext block. It recovers the plaintext one bit per clock, then runs the 256-step plaintext padding, and hands the resulting state to finalization for tag computation. It sits between `associated_process` and `finalization` in the decrypt path of `acorn128_top`.

## Interface
- No parameters; widths are fixed by ACORN-128. Constants live in the package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_dpi` in 1: start request, sampled only in IDLE.
- `state_in` in 293: state after AD processing; bit i is S[i].
- `ciphertext_in` in 128: ciphertext block; bit i is consumed at decrypt step i (LSB first).
- `plaintext_out` out 128: recovered plaintext; bit i is written at step i.
- `state_out` out 293: state after decrypt and padding; feeds finalization.
- `busy_out` out 1: high in DECRYPT and PAD.
- `done_out` out 1: high in DONE; outputs are valid while it is high.

## Operation
- FSM states: IDLE, DECRYPT, PAD, DONE. Step counter is 9 bits.
- **IDLE**
  - When `start_dpi`=1, latch `state_in` into the state register and `ciphertext_in` into the ciphertext register.
  - Clear `plaintext_out` and the counter, then go to DECRYPT.
- **Per step** (one per clock in DECRYPT and PAD), on the current state S:
  - S289 ^= S235^S230
  - S230 ^= S196^S193
  - S193 ^= S160^S154
  - S154 ^= S111^S107
  - S107 ^= S66^S61
  - S61 ^= S23^S0
  - All six updates are applied in this order; each later line reads the already-updated values.
- **Keystream:** ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66).
  - maj(x,y,z) = xy^xz^yz.
  - ch(x,y,z) = xy^(~x)z.
- **Feedback:** f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca&S196) ^ (cb&ks) ^ m.
- **Shift:** S[i] <= S[i+1] for i=0..291; S292 <= f.
- **DECRYPT** (steps 0..127):
  - p = `ciphertext_in`[i] ^ ks; store p into `plaintext_out`[i].
  - m = p, ca=1, cb=0.
  - After step 127, go to PAD.
- **PAD** (steps 128..383):
  - m = 1 at step 128, else 0.
  - ca=1 for steps 128..255, ca=0 for steps 256..383; cb=0.
  - No plaintext is written.
  - After step 383, go to DONE.
- **DONE**
  - Hold `plaintext_out`, `state_out` and `done_out`=1.
  - When `start_dpi`=1, re-latch and go to DECRYPT, exactly as from IDLE.
- `start_dpi` is ignored in DECRYPT and PAD.
- `rst` takes priority over everything, including mid-operation: the FSM returns to IDLE and all registers clear.
- The counter never wraps: it is compared against 127 and 383 and cleared on every start.

## Timing
- **Reset values:**
  - `plaintext_out`=0
  - `state_out`=0
  - `busy_out`=0
  - `done_out`=0
  - FSM in IDLE.
- **Cycle-level sequence**, with `start_dpi` sampled at edge k:
  - `busy_out` is 1 from edge k until edge k+384.
  - `plaintext_out`[i] updates at edge k+1+i, for i=0..127.
  - `done_out` rises at edge k+385.
  - Total latency is 385 cycles from start to done.
- `start_dpi` may be a single-cycle pulse or level-held. A held level in DONE restarts immediately; the top level drops it to avoid re-runs.
- `state_out` changes every cycle while busy and is meaningful only when `done_out`=1.

## Structure
- **`acorn128_pkg`** holds:
  - STATE_W=293, DATA_W=128, PAD_STEPS=256
  - FSM state typedef
  - maj/ch functions
  - tap-index constants
- **`acorn128_step`** (combinational sub-module)
  - Inputs: S, m, ca, cb. Outputs: next S, ks.
  - Shared with the encryption stage so both directions use identical update logic.
- The decryption FSM, counter and registers stay in this block; the intended size is about 200 lines.

## Test plan
1. **Reset:** reset asserted with `start_dpi`=1 → all outputs 0 and FSM in IDLE after the reset cycle. `busy_out` stays 0 while reset is held.
2. **Zero vectors:** `state_in`=0, `ciphertext_in`=0, start pulse at edge k.
   - `plaintext_out`[0]=0, because ks=0 on an all-zero state.
   - `done_out` rises at exactly edge k+385.
   - `plaintext_out` and `state_out` match the C golden model bit-for-bit.
3. **Round trip:** `encryption` with key=0, IV=0, empty AD and plaintext 128'h0123456789ABCDEF_FEDCBA9876543210 produces ciphertext C and a post-pad state. Feeding the same AD-stage state and C into this block → `plaintext_out` equals the original plaintext, and `state_out` equals the encryptor's post-pad state.
4. **Start while busy:** a second `start_dpi` with a different ciphertext at edge k+50 → ignored, and the result is identical to test 2.
5. **Reset mid-operation:** `rst` at edge k+200 → IDLE and outputs 0 on the next edge. A fresh start then completes correctly 385 cycles later.
6. **Restart from DONE:** while `done_out`=1, start with the test 3 vectors → `done_out` drops at the next edge, and the test 3 result appears 385 cycles after that start.

Source files
------------

// File: rtl/acorn128_pkg.sv
// acorn128_pkg: shared widths, taps and helpers
// for the ACORN-128 bit-serial stages.
package acorn128_pkg;

  localparam int STATE_W   = 293;
  localparam int DATA_W    = 128;
  localparam int PAD_STEPS = 256;
  localparam int CNT_W     = 9;

  localparam logic [CNT_W-1:0] LAST_DEC =
    CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PAD_FIRST =
    CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CA_END =
    CNT_W'(DATA_W + PAD_STEPS / 2);
  localparam logic [CNT_W-1:0] LAST_PAD =
    CNT_W'(DATA_W + PAD_STEPS - 1);

  localparam int T0   = 0;
  localparam int T12  = 12;
  localparam int T23  = 23;
  localparam int T61  = 61;
  localparam int T66  = 66;
  localparam int T107 = 107;
  localparam int T111 = 111;
  localparam int T154 = 154;
  localparam int T160 = 160;
  localparam int T193 = 193;
  localparam int T196 = 196;
  localparam int T230 = 230;
  localparam int T235 = 235;
  localparam int T244 = 244;
  localparam int T289 = 289;

  typedef enum logic [1:0] {
    IDLE,
    DECRYPT,
    PAD,
    DONE
  } fsm_e;

  function automatic logic maj(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// acorn128_step: one combinational ACORN-128
// state update, shared by both directions.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] s_in,
  input  logic               m_in,
  input  logic               ca_in,
  input  logic               cb_in,
  output logic [STATE_W-1:0] s_out,
  output logic               ks_out
);

  logic [STATE_W-1:0] u;
  logic               f;

  // chained LFSR merges, each reading the prior result
  always_comb begin
    u = s_in;
    u[T289] = u[T289] ^ u[T235] ^ u[T230];
    u[T230] = u[T230] ^ u[T196] ^ u[T193];
    u[T193] = u[T193] ^ u[T160] ^ u[T154];
    u[T154] = u[T154] ^ u[T111] ^ u[T107];
    u[T107] = u[T107] ^ u[T66] ^ u[T61];
    u[T61]  = u[T61] ^ u[T23] ^ u[T0];
  end

  // keystream depends only on state, never on m
  always_comb begin
    ks_out = u[T12] ^ u[T154]
           ^ maj(u[T235], u[T61], u[T193])
           ^ ch(u[T230], u[T111], u[T66]);
  end

  // feedback bit and one-position shift
  always_comb begin
    f = u[T0] ^ ~u[T107]
      ^ maj(u[T244], u[T23], u[T160])
      ^ (ca_in & u[T196])
      ^ (cb_in & ks_out)
      ^ m_in;
    s_out = {f, u[STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn128_decryption.sv
// acorn128_decryption: bit-serial decrypt of one
// 128-bit block followed by the 256-step padding.
module acorn128_decryption
  import acorn128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_dpi,
  input  logic [STATE_W-1:0] state_in,
  input  logic [DATA_W-1:0]  ciphertext_in,
  output logic [DATA_W-1:0]  plaintext_out,
  output logic [STATE_W-1:0] state_out,
  output logic               busy_out,
  output logic               done_out
);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  ct_q, ct_d;
  logic [DATA_W-1:0]  pt_q, pt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [STATE_W-1:0] s_nxt;
  logic               ks;
  logic               p;
  logic               m;
  logic               ca;

  acorn128_step u_step (
    .s_in   (state_q),
    .m_in   (m),
    .ca_in  (ca),
    .cb_in  (1'b0),
    .s_out  (s_nxt),
    .ks_out (ks)
  );

  // message bit and control bits for the current step
  always_comb begin
    p  = ct_q[cnt_q[6:0]] ^ ks;
    m  = 1'b0;
    ca = 1'b0;
    unique case (fsm_q)
      DECRYPT: begin
        m  = p;
        ca = 1'b1;
      end
      PAD: begin
        m  = (cnt_q == PAD_FIRST);
        ca = (cnt_q < CA_END);
      end
      default: ;
    endcase
  end

  // next-state, counter and data register updates
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    pt_d    = pt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE, DONE: begin
        done_d = (fsm_q == DONE);
        if (start_dpi) begin
          state_d = state_in;
          ct_d    = ciphertext_in;
          pt_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          fsm_d   = DECRYPT;
        end
      end
      DECRYPT: begin
        state_d = s_nxt;
        pt_d[cnt_q[6:0]] = p;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DEC) fsm_d = PAD;
      end
      PAD: begin
        state_d = s_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_PAD) fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // register bank with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ct_q    <= '0;
      pt_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      pt_q    <= pt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign plaintext_out = pt_q;
  assign state_out     = state_q;
  assign busy_out      = (fsm_q == DECRYPT) ||
                         (fsm_q == PAD);
  assign done_out      = done_q;

endmodule

// File: tb/tb_acorn128_decryption.sv
// tb_acorn128_decryption: directed checks of the
// decrypt engine against an in-bench reference.
module tb_acorn128_decryption;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_dpi = 1'b1;
  logic [292:0] state_in = '0;
  logic [127:0] ciphertext_in = '0;
  logic [127:0] plaintext_out;
  logic [292:0] state_out;
  logic         busy_out;
  logic         done_out;

  int total = 0;
  int bad = 0;

  acorn128_decryption dut (
    .clk           (clk),
    .rst           (rst),
    .start_dpi     (start_dpi),
    .state_in      (state_in),
    .ciphertext_in (ciphertext_in),
    .plaintext_out (plaintext_out),
    .state_out     (state_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [292:0] obs,
    input logic [292:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // reference ACORN-128 data + padding phase
  task automatic model_run(
    input  logic [292:0] s0,
    input  logic [127:0] din,
    input  bit           enc,
    output logic [127:0] dout,
    output logic [292:0] sf
  );
    logic [292:0] s;
    logic ks, m, ca, f, a, b, c;
    s = s0;
    dout = '0;
    for (int i = 0; i < 384; i++) begin
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66] ^ s[61];
      s[61]  = s[61] ^ s[23] ^ s[0];
      a = s[235]; b = s[61]; c = s[193];
      ks = s[12] ^ s[154]
         ^ ((a & b) | (a & c) | (b & c))
         ^ (s[230] ? s[111] : s[66]);
      if (i < 128) begin
        dout[i] = din[i] ^ ks;
        m  = enc ? din[i] : dout[i];
        ca = 1'b1;
      end else begin
        m  = (i == 128);
        ca = (i < 256);
      end
      a = s[244]; b = s[23]; c = s[160];
      f = s[0] ^ ~s[107]
        ^ ((a & b) | (a & c) | (b & c))
        ^ (ca & s[196]) ^ m;
      s = {f, s[292:1]};
    end
    sf = s;
  endtask

  // bounded wait for done, recording busy near the end
  task automatic wait_done(
    input  int   n0,
    output int   n,
    output logic b383,
    output logic b384
  );
    n = n0;
    b383 = 1'bx;
    b384 = 1'bx;
    while (n < 600) begin
      tick();
      n++;
      if (n == 383) b383 = busy_out;
      if (n == 384) b384 = busy_out;
      if (done_out) break;
    end
    if (!done_out) n = -1;
  endtask

  localparam logic [127:0] PT3 =
    128'h0123456789ABCDEF_FEDCBA9876543210;

  logic [292:0] s_ad;
  logic [127:0] c3;
  logic [292:0] s_enc;
  logic [127:0] pt_zero;
  logic [292:0] s_zero;
  int           n;
  logic         b383, b384;

  initial begin
    s_ad = {5'h15, {9{32'hA5C3_1E7B}}};
    model_run(s_ad, PT3, 1'b1, c3, s_enc);
    model_run('0, '0, 1'b0, pt_zero, s_zero);

    // reset held with start asserted
    tick();
    chk("rst_pt", 293'(plaintext_out), '0);
    chk("rst_state", state_out, '0);
    chk("rst_busy", 293'(busy_out), 293'(0));
    chk("rst_done", 293'(done_out), 293'(0));
    tick();
    chk("rst_busy2", 293'(busy_out), 293'(0));
    rst = 1'b0;
    start_dpi = 1'b0;
    tick();
    chk("idle_busy", 293'(busy_out), 293'(0));

    // zero vectors from IDLE
    state_in = '0;
    ciphertext_in = '0;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    chk("z_busy0", 293'(busy_out), 293'(1));
    tick();
    chk("z_pt0", 293'(plaintext_out[0]), 293'(0));
    chk("z_step1", state_out, {1'b1, 292'b0});
    wait_done(1, n, b383, b384);
    chk("z_lat", 293'(n), 293'(385));
    chk("z_busy383", 293'(b383), 293'(1));
    chk("z_busy384", 293'(b384), 293'(0));
    chk("z_pt", 293'(plaintext_out), 293'(pt_zero));
    chk("z_state", state_out, s_zero);

    // round trip, restarted from DONE
    state_in = s_ad;
    ciphertext_in = c3;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    chk("rt_done_drop", 293'(done_out), 293'(0));
    chk("rt_busy", 293'(busy_out), 293'(1));
    wait_done(0, n, b383, b384);
    chk("rt_lat", 293'(n), 293'(385));
    chk("rt_pt", 293'(plaintext_out), 293'(PT3));
    chk("rt_state", state_out, s_enc);
    chk("rt_done_hold", 293'(done_out), 293'(1));

    // start while busy is ignored
    state_in = '0;
    ciphertext_in = '0;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    ciphertext_in = {128{1'b1}};
    state_in = s_ad;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    wait_done(50, n, b383, b384);
    chk("bz_lat", 293'(n), 293'(385));
    chk("bz_pt", 293'(plaintext_out), 293'(pt_zero));
    chk("bz_state", state_out, s_zero);

    // reset in the middle of a run
    state_in = s_ad;
    ciphertext_in = c3;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    for (int i = 0; i < 199; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_pt", 293'(plaintext_out), '0);
    chk("mr_state", state_out, '0);
    chk("mr_busy", 293'(busy_out), 293'(0));
    chk("mr_done", 293'(done_out), 293'(0));
    state_in = '0;
    ciphertext_in = '0;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    wait_done(0, n, b383, b384);
    chk("mr_lat", 293'(n), 293'(385));
    chk("mr_res_pt", 293'(plaintext_out), 293'(pt_zero));
    chk("mr_res_state", state_out, s_zero);

    // restart from DONE with round-trip vectors
    state_in = s_ad;
    ciphertext_in = c3;
    start_dpi = 1'b1;
    tick();
    start_dpi = 1'b0;
    chk("rd_done_drop", 293'(done_out), 293'(0));
    wait_done(0, n, b383, b384);
    chk("rd_lat", 293'(n), 293'(385));
    chk("rd_pt", 293'(plaintext_out), 293'(PT3));
    chk("rd_state", state_out, s_enc);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
